// File: rtl/riscv_cpu_pkg.sv
// Shared pipeline types and constants for the CPU.
// Holds the EX->MEM and MEM->WB bundles plus the load/store size encodings.
package riscv_cpu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    REQ         = 2'b01,
    WAIT_RVALID = 2'b10
  } mem_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  reg_we;
  } id2ex_t;

  typedef struct packed {
    id2ex_t                id_stage;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic                  mem_req;
    logic                  mem_we;
    logic [1:0]            mem_size;
    logic                  mem_unsigned;
  } ex2mem_t;

  typedef struct packed {
    ex2mem_t               ex_stage;
    logic [DATA_WIDTH-1:0] mem_data;
  } mem2wb_t;

  // Size encoding 2'b11 is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic result;
    case (size)
      MEM_SIZE_BYTE: result = 1'b0;
      MEM_SIZE_HALF: result = addr_lo[0];
      default:       result = (addr_lo != 2'b00);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store lane alignment: byte enables, store data replication,
// misalignment detection and load data extraction with sign/zero extension.
module lsu_align
  import riscv_cpu_pkg::*;
(
  input  logic [1:0]            size,
  input  logic [1:0]            addr_lo,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  misaligned,
  output logic [DATA_WIDTH-1:0] rdata_fmt
);

  logic [DATA_WIDTH-1:0] lane;
  logic                  sign_bit;

  assign misaligned = is_misaligned(size, addr_lo);
  assign lane       = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be        = 4'b1111;
    wdata     = rs2_data;
    sign_bit  = 1'b0;
    rdata_fmt = rdata;
    case (size)
      MEM_SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{rs2_data[7:0]}};
        sign_bit  = ~is_unsigned & lane[7];
        rdata_fmt = {{24{sign_bit}}, lane[7:0]};
      end
      MEM_SIZE_HALF: begin
        be        = 4'b0011 << addr_lo;
        wdata     = {2{rs2_data[15:0]}};
        sign_bit  = ~is_unsigned & lane[15];
        rdata_fmt = {{16{sign_bit}}, lane[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata     = rs2_data;
        rdata_fmt = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one load/store per accepted bundle over a
// req/gnt/rvalid bus, with a registered one-cycle completion pulse towards WB.
module mem_stage
  import riscv_cpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  ex2mem_t               mem_pipeline_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output mem2wb_t               wb_pipeline_o,
  output logic                  valid_o,
  output logic                  misaligned_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [DATA_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);

  mem_state_e state_reg, state_next;
  ex2mem_t    bundle_reg, bundle_next;
  mem2wb_t    wb_reg, wb_next;
  logic       valid_reg, valid_next;
  logic       misaligned_reg, misaligned_next;

  logic [1:0]            acc_size;
  logic [DATA_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_rs2;
  logic                  acc_unsigned;
  logic [3:0]            align_be;
  logic [DATA_WIDTH-1:0] align_wdata;
  logic                  align_misaligned;
  logic [DATA_WIDTH-1:0] align_rdata;

  // In IDLE the aligner checks the incoming bundle; otherwise it drives the
  // bus and formats read data from the latched bundle, which stays frozen.
  always_comb begin
    if (state_reg == IDLE) begin
      acc_size     = mem_pipeline_i.mem_size;
      acc_addr     = mem_pipeline_i.alu_result;
      acc_rs2      = mem_pipeline_i.rs2_data;
      acc_unsigned = mem_pipeline_i.mem_unsigned;
    end else begin
      acc_size     = bundle_reg.mem_size;
      acc_addr     = bundle_reg.alu_result;
      acc_rs2      = bundle_reg.rs2_data;
      acc_unsigned = bundle_reg.mem_unsigned;
    end
  end

  lsu_align u_lsu_align (
    .size        (acc_size),
    .addr_lo     (acc_addr[1:0]),
    .is_unsigned (acc_unsigned),
    .rs2_data    (acc_rs2),
    .rdata       (data_rdata_i),
    .be          (align_be),
    .wdata       (align_wdata),
    .misaligned  (align_misaligned),
    .rdata_fmt   (align_rdata)
  );

  assign ready_o       = (state_reg == IDLE);
  assign data_req_o    = (state_reg == REQ);
  assign data_addr_o   = {acc_addr[DATA_WIDTH-1:2], 2'b00};
  assign data_we_o     = (state_reg == IDLE) ? mem_pipeline_i.mem_we : bundle_reg.mem_we;
  assign data_be_o     = align_be;
  assign data_wdata_o  = align_wdata;
  assign wb_pipeline_o = wb_reg;
  assign valid_o       = valid_reg;
  assign misaligned_o  = misaligned_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      bundle_reg     <= '0;
      wb_reg         <= '0;
      valid_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bundle_reg     <= bundle_next;
      wb_reg         <= wb_next;
      valid_reg      <= valid_next;
      misaligned_reg <= misaligned_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bundle_next     = bundle_reg;
    wb_next         = wb_reg;
    valid_next      = 1'b0;
    misaligned_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          if (!mem_pipeline_i.mem_req) begin
            wb_next.ex_stage = mem_pipeline_i;
            wb_next.mem_data = '0;
            valid_next       = 1'b1;
          end else if (align_misaligned) begin
            // Faulting access: retire immediately without touching the bus.
            wb_next.ex_stage                 = mem_pipeline_i;
            wb_next.ex_stage.id_stage.reg_we = 1'b0;
            wb_next.mem_data                 = '0;
            valid_next                       = 1'b1;
            misaligned_next                  = 1'b1;
          end else begin
            bundle_next = mem_pipeline_i;
            state_next  = REQ;
          end
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          if (bundle_reg.mem_we) begin
            wb_next.ex_stage                 = bundle_reg;
            wb_next.ex_stage.id_stage.reg_we = 1'b0;
            wb_next.mem_data                 = '0;
            valid_next                       = 1'b1;
            state_next                       = IDLE;
          end else begin
            state_next = WAIT_RVALID;
          end
        end
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          wb_next.ex_stage = bundle_reg;
          wb_next.mem_data = align_rdata;
          valid_next       = 1'b1;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: non-memory stream, loads, stores, misaligned
// access, reset mid-transaction, delayed rvalid.
module tb_mem_stage;
  import riscv_cpu_pkg::*;

  logic        clk;
  logic        rst;
  ex2mem_t     pipe;
  logic        vin;
  logic        ready;
  mem2wb_t     wb;
  logic        vout;
  logic        mis;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  int vectors;
  int miscompares;

  mem_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_pipeline_i (pipe),
    .valid_i        (vin),
    .ready_o        (ready),
    .wb_pipeline_o  (wb),
    .valid_o        (vout),
    .misaligned_o   (mis),
    .data_req_o     (req),
    .data_gnt_i     (gnt),
    .data_addr_o    (addr),
    .data_we_o      (we),
    .data_be_o      (be),
    .data_wdata_o   (wdata),
    .data_rvalid_i  (rvalid),
    .data_rdata_i   (rdata)
  );

  always #5 clk = ~clk;

  task automatic next;
    @(posedge clk);
    #2;
  endtask

  task automatic mid;
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ex2mem_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic rwe,
                                 input logic [31:0] alu, input logic [31:0] rs2, input logic mreq,
                                 input logic mwe, input logic [1:0] sz, input logic uns);
    ex2mem_t b;
    b.id_stage.pc      = pc;
    b.id_stage.rd_addr = rd;
    b.id_stage.reg_we  = rwe;
    b.alu_result       = alu;
    b.rs2_data         = rs2;
    b.mem_req          = mreq;
    b.mem_we           = mwe;
    b.mem_size         = sz;
    b.mem_unsigned     = uns;
    return b;
  endfunction

  // Load byte from 0x1003, gnt on first REQ cycle, rvalid right after.
  task automatic load_byte(input logic uns, input logic [31:0] exp_data);
    next; vin = 1; pipe = mk(32'h100, 5'd5, 1'b1, 32'h1003, 32'h0, 1'b1, 1'b0, MEM_SIZE_BYTE, uns);
    mid;  chk("lb_accept_ready", {31'b0, ready}, 1);
    next; vin = 0; gnt = 1;
    mid;  chk("lb_req", {31'b0, req}, 1);
          chk("lb_addr", addr, 32'h1000);
          chk("lb_be", {28'b0, be}, 32'h8);
          chk("lb_we", {31'b0, we}, 0);
          chk("lb_ready_stall", {31'b0, ready}, 0);
    next; gnt = 0; rvalid = 1; rdata = 32'h80FF_1234;
    mid;  chk("lb_req_wait", {31'b0, req}, 0);
          chk("lb_valid_early", {31'b0, vout}, 0);
    next; rvalid = 0;
    mid;  chk("lb_valid", {31'b0, vout}, 1);
          chk("lb_data", wb.mem_data, exp_data);
          chk("lb_reg_we", {31'b0, wb.ex_stage.id_stage.reg_we}, 1);
          chk("lb_ready_back", {31'b0, ready}, 1);
    next;
    mid;  chk("lb_valid_pulse", {31'b0, vout}, 0);
    $display("txn load_byte unsigned=%0d data=%h", uns, wb.mem_data);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    clk = 0; rst = 1; vin = 0; gnt = 0; rvalid = 0; rdata = '0; pipe = '0;
    next; next;
    rst = 0;
    mid;
    chk("rst_ready", {31'b0, ready}, 1);
    chk("rst_valid", {31'b0, vout}, 0);
    chk("rst_mis", {31'b0, mis}, 0);
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_wb_alu", wb.ex_stage.alu_result, 0);
    chk("rst_wb_data", wb.mem_data, 0);

    // Non-memory stream at one per cycle.
    next; vin = 1; pipe = mk(32'h4, 5'd1, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0);
    mid;  chk("nm0_ready", {31'b0, ready}, 1); chk("nm0_valid", {31'b0, vout}, 0);
    next; pipe.alu_result = 32'h20;
    mid;  chk("nm1_valid", {31'b0, vout}, 1); chk("nm1_alu", wb.ex_stage.alu_result, 32'h10);
          chk("nm1_ready", {31'b0, ready}, 1);
    next; pipe.alu_result = 32'h30;
    mid;  chk("nm2_valid", {31'b0, vout}, 1); chk("nm2_alu", wb.ex_stage.alu_result, 32'h20);
          chk("nm2_ready", {31'b0, ready}, 1);
    next; vin = 0;
    mid;  chk("nm3_valid", {31'b0, vout}, 1); chk("nm3_alu", wb.ex_stage.alu_result, 32'h30);
    next;
    mid;  chk("nm4_valid", {31'b0, vout}, 0); chk("nm4_hold", wb.ex_stage.alu_result, 32'h30);
    $display("txn non_mem stream of 3 done");

    load_byte(1'b0, 32'hFFFF_FF80);
    load_byte(1'b1, 32'h0000_0080);

    // Store half with grant delayed 4 cycles.
    next; vin = 1; pipe = mk(32'h200, 5'd7, 1'b1, 32'h2002, 32'hDEAD_BEEF, 1'b1, 1'b1, MEM_SIZE_HALF, 1'b0);
    mid;  chk("sh_accept_req", {31'b0, req}, 0);
    next; vin = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) gnt = 1;
      mid;
      chk("sh_req", {31'b0, req}, 1);
      chk("sh_addr", addr, 32'h2000);
      chk("sh_be", {28'b0, be}, 32'hC);
      chk("sh_wdata", wdata, 32'hBEEF_BEEF);
      chk("sh_we", {31'b0, we}, 1);
      chk("sh_ready", {31'b0, ready}, 0);
      chk("sh_valid", {31'b0, vout}, 0);
      next;
    end
    gnt = 0;
    mid;  chk("sh_done_valid", {31'b0, vout}, 1);
          chk("sh_done_reg_we", {31'b0, wb.ex_stage.id_stage.reg_we}, 0);
          chk("sh_done_ready", {31'b0, ready}, 1);
          chk("sh_done_req", {31'b0, req}, 0);
    next;
    mid;  chk("sh_valid_pulse", {31'b0, vout}, 0);
    $display("txn store_half addr=2002");

    // Store byte, immediate grant.
    next; vin = 1; pipe = mk(32'h204, 5'd0, 1'b0, 32'h7001, 32'h0000_00A5, 1'b1, 1'b1, MEM_SIZE_BYTE, 1'b0);
    mid;
    next; vin = 0; gnt = 1;
    mid;  chk("sb_be", {28'b0, be}, 32'h2); chk("sb_wdata", wdata, 32'hA5A5_A5A5);
          chk("sb_addr", addr, 32'h7000);
    next; gnt = 0;
    mid;  chk("sb_valid", {31'b0, vout}, 1);
    $display("txn store_byte addr=7001");

    // Half load, signed, upper lane.
    next; vin = 1; pipe = mk(32'h208, 5'd9, 1'b1, 32'h6002, 32'h0, 1'b1, 1'b0, MEM_SIZE_HALF, 1'b0);
    mid;
    next; vin = 0; gnt = 1;
    mid;  chk("lh_be", {28'b0, be}, 32'hC);
    next; gnt = 0; rvalid = 1; rdata = 32'h8001_7FFF;
    mid;
    next; rvalid = 0;
    mid;  chk("lh_data", wb.mem_data, 32'hFFFF_8001); chk("lh_valid", {31'b0, vout}, 1);
    $display("txn load_half addr=6002");

    // Misaligned word load.
    next; vin = 1; pipe = mk(32'h300, 5'd3, 1'b1, 32'h3001, 32'h0, 1'b1, 1'b0, MEM_SIZE_WORD, 1'b0);
    mid;  chk("mis_accept_req", {31'b0, req}, 0);
    next; vin = 0;
    mid;  chk("mis_req", {31'b0, req}, 0);
          chk("mis_valid", {31'b0, vout}, 1);
          chk("mis_flag", {31'b0, mis}, 1);
          chk("mis_reg_we", {31'b0, wb.ex_stage.id_stage.reg_we}, 0);
          chk("mis_ready", {31'b0, ready}, 1);
    next;
    mid;  chk("mis_valid_pulse", {31'b0, vout}, 0); chk("mis_flag_pulse", {31'b0, mis}, 0);
    $display("txn misaligned word load addr=3001");

    // Reset while waiting for rvalid; late rvalid must be ignored.
    next; vin = 1; pipe = mk(32'h400, 5'd4, 1'b1, 32'h4000, 32'h0, 1'b1, 1'b0, MEM_SIZE_WORD, 1'b0);
    mid;
    next; vin = 0; gnt = 1;
    mid;
    next; gnt = 0; rst = 1;
    mid;  chk("rw_wait_ready", {31'b0, ready}, 0); chk("rw_wait_req", {31'b0, req}, 0);
    next; rst = 0; rvalid = 1; rdata = 32'h1234_5678;
    mid;  chk("rw_idle_ready", {31'b0, ready}, 1); chk("rw_no_valid", {31'b0, vout}, 0);
    next; rvalid = 0; vin = 1; pipe = mk(32'h404, 5'd2, 1'b1, 32'h55, 32'h0, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0);
    mid;  chk("rw_late_ignored", {31'b0, vout}, 0); chk("rw_data_clear", wb.mem_data, 0);
          chk("rw_req", {31'b0, req}, 0);
    next; vin = 0;
    mid;  chk("rw_next_valid", {31'b0, vout}, 1); chk("rw_next_alu", wb.ex_stage.alu_result, 32'h55);
    $display("txn reset in WAIT_RVALID, recovery op done");

    // Word load with rvalid delayed 3 cycles.
    next; vin = 1; pipe = mk(32'h500, 5'd6, 1'b1, 32'h5004, 32'h0, 1'b1, 1'b0, MEM_SIZE_WORD, 1'b1);
    mid;
    next; vin = 0; gnt = 1;
    mid;  chk("lw_addr", addr, 32'h5004); chk("lw_be", {28'b0, be}, 32'hF);
          chk("lw_ready", {31'b0, ready}, 0);
    next; gnt = 0;
    for (int i = 0; i < 3; i++) begin
      mid; chk("lw_wait_ready", {31'b0, ready}, 0); chk("lw_wait_valid", {31'b0, vout}, 0);
      next;
    end
    rvalid = 1; rdata = 32'hCAFE_F00D;
    mid;  chk("lw_rv_ready", {31'b0, ready}, 0);
    next; rvalid = 0;
    mid;  chk("lw_valid", {31'b0, vout}, 1); chk("lw_data", wb.mem_data, 32'hCAFE_F00D);
          chk("lw_ready_back", {31'b0, ready}, 1);
    $display("txn load_word addr=5004 data=%h", wb.mem_data);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between EX and WB.
- Accepts one ex2mem_t bundle at a time and performs at most one data-memory transaction for it (load or store) over a req/gnt/rvalid bus.
- Formats load data (byte/half/word, sign or zero extension) and presents a registered mem2wb_t bundle with a one-cycle valid pulse to the WB stage.
- Stalls EX through ready_o while a transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, data/address bus width (package constant, fixed at 32).
- ADDR_WIDTH, 5, register-file index width (package constant; passes through inside the bundle).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- mem_pipeline_i  in  ex2mem_t  EX→MEM bundle: id_stage fields, alu_result (= address), rs2_data, mem_req, mem_we, mem_size[1:0], mem_unsigned
- valid_i  in  1  mem_pipeline_i valid
- ready_o  out  1  stage can accept; transfer when valid_i && ready_o
- wb_pipeline_o  out  mem2wb_t  registered bundle to WB: ex_stage copy plus mem_data
- valid_o  out  1  one-cycle pulse per completed instruction
- misaligned_o  out  1  pulse with valid_o when the access was misaligned
- data_req_o  out  1  memory request
- data_gnt_i  in  1  request accepted
- data_addr_o  out  32  word-aligned address {alu_result[31:2],2'b00}
- data_we_o  out  1  1 = store
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  store data, replicated to byte lanes
- data_rvalid_i  in  1  read data valid
- data_rdata_i  in  32  read data

Behaviour:
- Reset (rst_i=1 at a clk_i edge): state IDLE; valid_o=0, misaligned_o=0, data_req_o=0, wb_pipeline_o=0, internal bundle register=0. ready_o is combinational: 1 only in IDLE.
- FSM states: IDLE, REQ, WAIT_RVALID.
- IDLE, accept with mem_req=0:
  - wb_pipeline_o <= {mem_pipeline_i, mem_data=0}; valid_o=1 next cycle (latency 1); stay IDLE.
  - Back-to-back non-memory ops sustain 1/cycle.
- IDLE, accept with mem_req=1 and misaligned (half with addr[0]=1; word with addr[1:0]!=0):
  - No bus request.
  - Next cycle: valid_o=1, misaligned_o=1, wb reg_we forced 0; stay IDLE.
- IDLE, accept with mem_req=1 and aligned: latch bundle → REQ.
- REQ:
  - data_req_o=1 with addr/we/be/wdata from the latched bundle; all bus outputs held stable until data_gnt_i.
  - On gnt, store: valid_o=1 next cycle, reg_we forced 0 → IDLE.
  - On gnt, load: → WAIT_RVALID.
- WAIT_RVALID:
  - data_req_o=0.
  - On data_rvalid_i: mem_data <= formatted rdata; valid_o=1 next cycle → IDLE.
- Minimum latency from accept to valid_o: store 2 cycles, load 3 cycles.
- Byte enables by mem_size / addr[1:0]:
  - byte (00): 4'b0001 << a.
  - half (01): 4'b0011 << a.
  - word (10): 4'b1111.
  - mem_size 11 is treated as word.
- wdata: byte → {4{rs2[7:0]}}; half → {2{rs2[15:0]}}; word → rs2.
- Load formatting:
  - Select lane by addr[1:0].
  - Sign-extend when mem_unsigned=0, zero-extend when mem_unsigned=1.
- valid_o and misaligned_o are single-cycle pulses. wb_pipeline_o holds its value until the next completion.
- rvalid while not in WAIT_RVALID (e.g. after reset mid-transaction) is ignored.
- gnt while data_req_o=0 is ignored.
- Reset during REQ or WAIT_RVALID:
  - Return to IDLE next cycle, data_req_o=0, no valid_o.
  - The in-flight instruction is dropped.

Decomposition:
- riscv_cpu_pkg:
  - Extend ex2mem_t with rs2_data, mem_req, mem_we, mem_size, mem_unsigned.
  - Add constants MEM_SIZE_BYTE/HALF/WORD and a mem_state_e enum.
  - mem2wb_t is unchanged.
- Sub-module lsu_align (combinational):
  - Computes be, wdata and misaligned from size/addr/rs2.
  - Formats rdata from size/addr/unsigned.
  - Reused by any future LSU.

Test Plan:
- Non-memory stream: 3 consecutive accepts, alu_result 0x10, 0x20, 0x30 → valid_o pulses on 3 consecutive cycles, each 1 cycle after its accept, ready_o=1 throughout.
- Load byte signed:
  - Stimulus: addr 0x1003, rdata 0x80FF_1234, gnt on first REQ cycle, rvalid next cycle.
  - Required: data_addr_o=0x1000, data_be_o=4'b1000, mem_data=0xFFFF_FF80, valid_o 3 cycles after accept.
  - Repeat with mem_unsigned=1 → mem_data=0x0000_0080.
- Store half:
  - Stimulus: addr 0x2002, rs2 0xDEAD_BEEF, gnt delayed 4 cycles.
  - Required: data_req_o held 5 cycles with stable bus outputs, data_be_o=4'b1100, data_wdata_o=0xBEEF_BEEF, data_we_o=1, ready_o=0 during stall, valid_o with reg_we=0 one cycle after gnt.
- Misaligned word load, addr 0x3001 → no data_req_o, valid_o and misaligned_o pulse 1 cycle later, reg_we=0.
- Reset in WAIT_RVALID: assert rst_i one cycle → IDLE, no valid_o; a late rvalid with rdata 0x1234_5678 is ignored, and the next non-memory op completes normally.
- Load word with rvalid delayed 3 cycles → mem_data=rdata exactly, ready_o low from accept until the cycle after rvalid.
